bad_alu: RTL and testbench



---
 rtl/bad_alu.sv | 74 +++++++
 tb/tb_bad_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bad_alu.sv
// 32-bit combinational ALU for the single-cycle MIPS datapath.
// Sticky overflow and illegal-opcode flags are the only registered state.
`timescale 1ns/1ps
module bad_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluop,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf,
    output logic        ovf_sticky,
    output logic        badop_sticky
);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0100;
    localparam logic [3:0] OpOr  = 4'b0101;
    localparam logic [3:0] OpXor = 4'b0110;
    localparam logic [3:0] OpNor = 4'b0111;
    localparam logic [3:0] OpSlt = 4'b1010;

    logic        sub;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        add_ovf;
    logic        slt;
    logic        badop;
    logic        ovf_sticky_d;
    logic        badop_sticky_d;

    // Shared adder: aluop[1] turns it into a - b for SUB and SLT.
    assign sub     = aluop[1];
    assign b_eff   = sub ? ~b : b;
    assign sum     = a + b_eff + {31'd0, sub};
    assign add_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    // Sign of the difference, corrected when the subtraction overflowed.
    assign slt     = sum[31] ^ add_ovf;

    always_comb begin
        result = 32'h0000_0000;
        badop  = 1'b0;
        case (aluop)
            OpAdd:   result = sum;
            OpSub:   result = sum;
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpNor:   result = ~(a | b);
            OpSlt:   result = {31'd0, slt};
            default: badop  = 1'b1;
        endcase
    end

    assign zero = (result == 32'h0000_0000);
    assign ovf  = add_ovf && ((aluop == OpAdd) || (aluop == OpSub));

    always_comb begin
        ovf_sticky_d   = ovf_sticky | ovf;
        badop_sticky_d = badop_sticky | badop;
        if (reset) begin
            ovf_sticky_d   = 1'b0;
            badop_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ovf_sticky   <= ovf_sticky_d;
        badop_sticky <= badop_sticky_d;
    end

endmodule

// File: tb/tb_bad_alu.sv
// Directed and swept self-checking bench for bad_alu.
`timescale 1ns/1ps
module tb_bad_alu;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluop;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        ovf_sticky;
    logic        badop_sticky;

    int checks = 0;
    int errors = 0;

    bad_alu dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .aluop        (aluop),
        .result       (result),
        .zero         (zero),
        .ovf          (ovf),
        .ovf_sticky   (ovf_sticky),
        .badop_sticky (badop_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive 20 ns after an edge, check 80 ns after it.
    task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp_res,
                       input logic exp_zero);
        @(posedge clk);
        #20;
        aluop = op;
        a     = va;
        b     = vb;
        #60;
        check({tag, ".result"}, result, exp_res);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    endtask

    // Reference model built from plain operators, independent of the adder structure.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        case (op)
            4'b0000: return x + y;
            4'b0010: return x - y;
            4'b0100: return x & y;
            4'b0101: return x | y;
            4'b0110: return x ^ y;
            4'b0111: return ~(x | y);
            4'b1010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
        logic [32:0] s;
        if (op == 4'b0000) s = {x[31], x} + {y[31], y};
        else if (op == 4'b0010) s = {x[31], x} - {y[31], y};
        else return 1'b0;
        return s[32] != s[31];
    endfunction

    initial begin
        logic [3:0]  ops [10];
        logic [31:0] edges [5];
        logic [31:0] er;

        ops   = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010,
                  4'b1111, 4'b0001, 4'b1011};
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

        reset = 1'b1;
        aluop = 4'b0000;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #20 reset = 1'b0;
        #1;
        check("rst.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("rst.badop_sticky", {31'd0, badop_sticky}, 32'd0);

        vec("add", 4'b0000, 32'h5, 32'h3, 32'h8, 1'b0);
        vec("sub_eq", 4'b0010, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1);
        vec("sub_neg", 4'b0010, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
        vec("and", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        vec("or", 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        vec("xor", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        vec("nor", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0);
        vec("slt_m1_1", 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
        vec("slt_1_m1", 4'b1010, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        vec("slt_min_max", 4'b1010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0);
        check("slt_min_max.ovf", {31'd0, ovf}, 32'd0);
        vec("slt_eq", 4'b1010, 32'hABCD_0123, 32'hABCD_0123, 32'h0, 1'b1);

        // No ADD/SUB so far overflowed and no illegal op was clocked.
        @(posedge clk);
        #1;
        check("pre.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("pre.badop_sticky", {31'd0, badop_sticky}, 32'd0);

        vec("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        check("add_ovf.ovf", {31'd0, ovf}, 32'd1);
        @(posedge clk);
        #1;
        check("add_ovf.ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
        vec("after_ovf", 4'b0000, 32'h2, 32'h2, 32'h4, 1'b0);
        check("after_ovf.ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        #1;
        check("hold.ovf_sticky", {31'd0, ovf_sticky}, 32'd1);

        // Reset pulse must not disturb the combinational result.
        #19 reset = 1'b1;
        #10;
        check("rst_mid.result", result, 32'h4);
        @(posedge clk);
        #1;
        check("rst_pulse.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        #19 reset = 1'b0;

        vec("badop", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("badop.badop_sticky", {31'd0, badop_sticky}, 32'd1);
        check("badop.ovf_sticky", {31'd0, ovf_sticky}, 32'd0);

        // Reset on the same edge as an illegal op wins.
        #19 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_vs_badop.badop_sticky", {31'd0, badop_sticky}, 32'd0);
        #19;
        reset = 1'b0;
        aluop = 4'b0000;
        @(posedge clk);
        #1;
        check("post_rst.badop_sticky", {31'd0, badop_sticky}, 32'd0);

        for (int i = 0; i < 120; i++) begin
            logic [3:0]  op;
            logic [31:0] va;
            logic [31:0] vb;
            op = ops[i % 10];
            va = (i % 3 == 0) ? edges[(i / 3) % 5] : $urandom;
            vb = (i % 4 == 1) ? edges[(i / 4) % 5] : $urandom;
            if (i % 17 == 5) vb = va;
            er = ref_result(op, va, vb);
            vec($sformatf("sweep%0d_op%b", i, op), op, va, vb, er, er == 32'd0);
            check($sformatf("sweep%0d.ovf", i), {31'd0, ovf}, {31'd0, ref_ovf(op, va, vb)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
